// File: rtl/uart_rx.sv
// UART receive framer: start-edge detect, mid-bit sampling, LSB-first shift,
// stop-bit check, and a one-entry holding register drained by valid/ack.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_serial low
// ST_START | counting to mid start bit, re-checking the line
// ST_DATA  | sampling data bits at their mid-points
// ST_STOP  | sampling the stop bit, handing off or flagging an error
// ST_BREAK | stop bit was low; waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state;
  logic [CW-1:0]        cycle_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cycle_cnt   <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      framing_err <= 1'b0;

      // consumer drain; a drop flagged later in this block overrides the clear
      if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_serial) begin
            state     <= ST_START;
            cycle_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        ST_START: begin
          if (cycle_cnt == HALF_LAST) begin
            cycle_cnt <= '0;
            if (!rx_serial) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt <= '0;
            shift_reg <= (shift_reg >> 1) | (DATA_BITS'(rx_serial) << (DATA_BITS - 1));
            if (bit_idx == IDX_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
          end
        end

        ST_STOP: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt <= '0;
            if (rx_serial) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              if (!data_valid || data_ack) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
          end
        end

        ST_BREAK: begin
          if (rx_serial) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, compared against
// a frame-level model of the holding register (valid / data / overrun).
module tb_uart_rx;

  localparam int C  = 16;
  localparam int DB = 8;
  localparam int H  = C / 2;
  localparam int STOP_OBS = H + (DB + 1) * C + 1;   // cycle after the stop sample

  logic          clock;
  logic          reset;
  logic          rx_serial;
  logic          data_ack;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          framing_err;
  logic          overrun;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  // frame-level reference state
  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data  = '0;
  logic          m_ov    = 1'b0;

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // line level k cycles after the start edge of a frame
  function automatic logic line_bit(input logic [DB-1:0] d, input logic stop, input int k);
    int slot;
    slot = k / C;
    if (slot == 0) return 1'b0;
    else if (slot <= DB) return d[slot-1];
    else if (slot == DB + 1) return stop;
    else return 1'b1;
  endfunction

  // frame outcome by the handoff rules, applied once per completed frame
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic ack);
    if (ack && m_valid) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    if (stop) begin
      if (m_valid) m_ov = 1'b1;
      else begin
        m_data  = d;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_serial = 1'b1;
      data_ack  = 1'b0;
    end
  endtask

  // step k observes the cycle t0+k, then drives the line for edge t0+k
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic ack_at_stop);
    for (int k = 0; k < (DB + 2) * C; k++) begin
      @(negedge clock);
      if (k == 1) check("busy_after_start", busy, 1);
      if (k == STOP_OBS - 1) begin
        check("valid_before_stop", data_valid, m_valid);
        check("fe_before_stop", framing_err, 0);
      end
      if (k == STOP_OBS) begin
        model_frame(d, stop, ack_at_stop);
        check("valid_after_stop", data_valid, m_valid);
        check("data_after_stop", data_out, m_data);
        check("overrun_after_stop", overrun, m_ov);
        check("fe_pulse", framing_err, !stop);
      end
      if (k == STOP_OBS + 1) check("fe_one_cycle", framing_err, 0);
      rx_serial = line_bit(d, stop, k);
      data_ack  = ack_at_stop && (k == STOP_OBS - 1);
    end
  endtask

  task automatic do_ack();
    @(negedge clock);
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    check("ack_valid", data_valid, m_valid);
    check("ack_overrun", overrun, m_ov);
    check("ack_data_hold", data_out, m_data);
  endtask

  initial begin
    reset     = 1'b1;
    rx_serial = 1'b1;
    data_ack  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_fe", framing_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    idle(5);

    // single good frame then drain
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3);
    do_ack();
    idle(3);

    // start glitch: four low cycles
    for (int k = 0; k < 2 * C; k++) begin
      @(negedge clock);
      if (k == H) check("glitch_busy_hold", busy, 1);
      if (k == H + 1) check("glitch_busy_drop", busy, 0);
      if (framing_err !== 1'b0) check("glitch_fe", framing_err, 0);
      rx_serial = (k < 4) ? 1'b0 : 1'b1;
    end
    check("glitch_valid", data_valid, m_valid);

    // framing error with a long low line, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (24) @(negedge clock);
    @(negedge clock);
    check("break_busy", busy, 1);
    check("break_valid", data_valid, 0);
    rx_serial = 1'b1;
    @(negedge clock);
    check("break_exit_busy", busy, 0);
    idle(2);
    send_frame(8'h55, 1'b1, 1'b0);
    do_ack();

    // overrun on back-to-back frames
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_data_kept", data_out, 8'h11);
    do_ack();

    // ack coinciding with the stop sample
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    check("simul_data", data_out, 8'h77);

    // reset during data bit 3
    for (int k = 0; k < 5 * C; k++) begin
      @(negedge clock);
      if (k == 71) begin
        check("midrst_busy", busy, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_data", data_out, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_fe", framing_err, 0);
        reset = 1'b0;
      end
      rx_serial = (k >= 70) ? 1'b1 : line_bit(8'hF0, 1'b1, k);
      if (k == 70) reset = 1'b1;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_ov    = 1'b0;
    idle(12 * C);
    check("midrst_no_output", data_valid, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    do_ack();

    // random frames, stop bits and ack placement
    for (int n = 0; n < 20; n++) begin
      logic [DB-1:0] d;
      logic          stop;
      logic          ack_stop;
      d        = DB'($urandom);
      stop     = ($urandom_range(0, 5) != 0);
      ack_stop = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) do_ack();
      send_frame(d, stop, ack_stop);
      idle(stop ? $urandom_range(0, 3) : 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive framer for the UART datapath. It takes the already-synchronized serial line (output of the two-flop synchronizer) and detects start bits. It samples each bit at its mid-point, shifts data LSB-first into an internal register, and checks the stop bit. Each completed byte goes into a one-entry holding register with a valid/ack handshake, which the downstream command/FIFO logic drains.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per frame; no parity; one stop bit

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
rx_serial  input  1  synchronized serial line; idles high
data_ack  input  1  consumer takes data_out this cycle; ignored when data_valid=0
data_out  output  DATA_BITS  last accepted byte, bit 0 = first bit received
data_valid  output  1  holding register full; held until acked
framing_err  output  1  one-cycle pulse when the stop bit is sampled low
overrun  output  1  sticky; a completed byte was dropped because holding was full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; bit counter, cycle counter, shift register, data_out cleared to 0; data_valid=0, framing_err=0, overrun=0, busy=0.
- Reset asserted mid-frame aborts the frame with no output. After reset deasserts, a line already low is treated as a new start edge.
- Definitions: C=CLKS_PER_BIT, H=C/2 (integer division). t0 is the first cycle in IDLE where rx_serial=0 is sampled.
- IDLE: on rx_serial=0 go to START and clear the cycle counter. busy rises at t0+1.
- START: at t0+H, re-sample rx_serial.
  - 0: go to DATA, bit index 0.
  - 1: treat as a glitch; return to IDLE with no outputs.
- DATA: bit i (0..DATA_BITS-1) is sampled at t0+H+(i+1)*C and shifted in LSB-first. After the last bit, go to STOP.
- STOP: the stop bit is sampled at t0+H+(DATA_BITS+1)*C.
  - 1: the frame is good. Return to IDLE the next cycle (mid stop bit), so a start edge is detectable from the following cycle.
  - 0: pulse framing_err for exactly the next cycle and discard the byte. Go to BREAK, which waits for rx_serial=1, then to IDLE. No start detection happens in BREAK.
- Good frame handoff, visible the cycle after the stop sample:
  - data_valid=0, or data_valid=1 with data_ack=1 in the stop-sample cycle: load data_out and set data_valid=1.
  - data_valid=1 and data_ack=0: keep the old data_out and set overrun=1.
- Handshake: data_ack=1 while data_valid=1 clears data_valid on the next edge. data_out holds its value until the next load.
- overrun clears on any cycle with data_ack=1 and data_valid=1. If a new drop happens in that same cycle, set wins.
- Total latency: data_valid rises at t0+H+(DATA_BITS+1)*C+1. With C=16 and DATA_BITS=8 this is t0+153.
- Counter width: $clog2(C) bits for the cycle counter and $clog2(DATA_BITS+1) bits for the bit index. The cycle counter restarts at every sample point; it never free-runs or wraps.
- rx_serial changes between sample points are ignored; there is no majority voting.
- busy=1 in START, DATA, STOP and BREAK.

Test Plan:
1. C=16, DATA_BITS=8. Send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1), each bit held 16 cycles -> data_out=0xA5, data_valid=1 at t0+153, framing_err=0. After data_ack=1 for one cycle, data_valid=0 next edge.
2. Glitch: hold rx_serial low for 4 cycles, then high -> at t0+8 back to IDLE, busy=0 from t0+9, no data_valid or framing_err.
3. Framing error: send 0x3C with stop bit=0, hold low 40 cycles, then high -> framing_err high for exactly cycle t0+153, data_valid stays 0. busy stays 1 until one cycle after the line returns high. A following 0x55 frame is then received correctly.
4. Overrun: send 0x11 then 0x22 back-to-back with no ack -> data_out=0x11, data_valid=1, overrun=1 after the second stop sample. One data_ack -> data_valid=0, overrun=0.
5. Simultaneous: data_valid=1 holding 0x11; assert data_ack in the same cycle as the stop sample of 0x77 -> next cycle data_out=0x77, data_valid=1, overrun=0.
6. Reset mid-frame: pulse reset during data bit 3 of 0xF0 with the line then idle -> all outputs 0, state IDLE, no data_valid. A subsequent 0x0F frame is received correctly.
